// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, variable-latency memory between the instruction
//   fetch port and the data (MEM-stage) port. Data wins by default; a
//   saturating streak counter forces a fetch grant after MAX_D_STREAK
//   consecutive data grants taken while a fetch was waiting.
//
// Ports
//   clock, reset           : single clock, synchronous active-high reset
//   if_req/if_addr         : fetch request and word address (held to if_ready)
//   if_rdata/if_ready      : fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : data request (held to dm_ready)
//   dm_rdata/dm_ready      : load data, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata : memory request, held until mem_ack
//   mem_rdata/mem_ack      : memory read data and completion
//   pipe_stall             : combinational freeze request to the core
module mem_port_arbiter #(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        pipe_stall
);

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned STREAK_W =
      ($clog2(MAX_D_STREAK + 1) > 3) ? $clog2(MAX_D_STREAK + 1) : 3;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_IACC  = 3'd1,
      S_DACC  = 3'd2,
      S_IRESP = 3'd3,
      S_DRESP = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_mem_req;
   logic                r_mem_we;
   logic [DATA_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_dm_rdata;
   logic                r_if_ready;
   logic                r_dm_ready;
   logic [STREAK_W-1:0] r_streak;

   logic                w_mem_req_nxt;
   logic                w_mem_we_nxt;
   logic [DATA_W-1:0]   w_mem_addr_nxt;
   logic [DATA_W-1:0]   w_mem_wdata_nxt;
   logic [DATA_W-1:0]   w_if_rdata_nxt;
   logic [DATA_W-1:0]   w_dm_rdata_nxt;
   logic                w_if_ready_nxt;
   logic                w_dm_ready_nxt;
   logic [STREAK_W-1:0] w_streak_nxt;

   logic                w_grant_d;
   logic                w_grant_i;
   logic [STREAK_W-1:0] w_streak_inc;

   // Arbitration: data unless a waiting fetch has been passed over MAX times
   always_comb begin
      w_grant_d    = dm_req && (!if_req || (r_streak < STREAK_MAX));
      w_grant_i    = if_req && !w_grant_d;
      w_streak_inc = (r_streak < STREAK_MAX) ? (r_streak + STREAK_W'(1)) : r_streak;
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant_d)      w_state_nxt = S_DACC;
            else if (w_grant_i) w_state_nxt = S_IACC;
         end
         S_IACC:  if (mem_ack) w_state_nxt = S_IRESP;
         S_DACC:  if (mem_ack) w_state_nxt = S_DRESP;
         S_IRESP: w_state_nxt = S_IDLE;
         S_DRESP: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic: next values for the registered outputs
   always_comb begin
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_if_rdata_nxt  = r_if_rdata;
      w_dm_rdata_nxt  = r_dm_rdata;
      w_if_ready_nxt  = 1'b0;
      w_dm_ready_nxt  = 1'b0;
      w_streak_nxt    = r_streak;
      case (r_state)
         S_IDLE: begin
            if (w_grant_d) begin
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = dm_we;
               w_mem_addr_nxt  = dm_addr;
               w_mem_wdata_nxt = dm_wdata;
               // Only data grants that bypass a waiting fetch count
               w_streak_nxt    = if_req ? w_streak_inc : '0;
            end else if (w_grant_i) begin
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = 1'b0;
               w_mem_addr_nxt  = if_addr;
               w_mem_wdata_nxt = '0;
               w_streak_nxt    = '0;
            end
         end
         S_IACC: begin
            if (mem_ack) begin
               w_mem_req_nxt  = 1'b0;
               w_if_rdata_nxt = mem_rdata;
               w_if_ready_nxt = 1'b1;
            end
         end
         S_DACC: begin
            if (mem_ack) begin
               w_mem_req_nxt  = 1'b0;
               // Stores leave the last load value in place
               if (!r_mem_we) w_dm_rdata_nxt = mem_rdata;
               w_dm_ready_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_if_ready  <= 1'b0;
         r_dm_ready  <= 1'b0;
         r_streak    <= '0;
      end else begin
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_if_rdata  <= w_if_rdata_nxt;
         r_dm_rdata  <= w_dm_rdata_nxt;
         r_if_ready  <= w_if_ready_nxt;
         r_dm_ready  <= w_dm_ready_nxt;
         r_streak    <= w_streak_nxt;
      end
   end

   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign if_rdata   = r_if_rdata;
   assign dm_rdata   = r_dm_rdata;
   assign if_ready   = r_if_ready;
   assign dm_ready   = r_dm_ready;
   assign pipe_stall = (if_req & ~r_if_ready) | (dm_req & ~r_dm_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs change and outputs are
//   sampled on the falling edge; the memory side is driven by hand.
module tb_mem_port_arbiter;

   logic        clock;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        pipe_stall;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ready  (if_ready),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_ready  (dm_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .pipe_stall(pipe_stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: the rising edge happens, then we land on the falling edge
   task automatic step();
      @(negedge clock);
   endtask

   initial begin
      logic [31:0] exp_addr;
      logic [31:0] pc;
      logic [31:0] da;

      reset = 1'b1; if_req = 1'b1; if_addr = 32'h0040_0000;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      mem_rdata = '0; mem_ack = 1'b0;

      // Reset held two cycles with a pending fetch
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_mem_req",   32'(mem_req),    32'd0);
         chk("rst_mem_we",    32'(mem_we),     32'd0);
         chk("rst_mem_addr",  mem_addr,        32'd0);
         chk("rst_mem_wdata", mem_wdata,       32'd0);
         chk("rst_if_ready",  32'(if_ready),   32'd0);
         chk("rst_dm_ready",  32'(dm_ready),   32'd0);
         chk("rst_if_rdata",  if_rdata,        32'd0);
         chk("rst_dm_rdata",  dm_rdata,        32'd0);
         chk("rst_stall",     32'(pipe_stall), 32'd1);
      end

      // Lone fetch, zero-wait memory
      reset = 1'b0;
      step();
      chk("if_mem_req",  32'(mem_req), 32'd1);
      chk("if_mem_addr", mem_addr,     32'h0040_0000);
      chk("if_mem_we",   32'(mem_we),  32'd0);
      chk("if_stall",    32'(pipe_stall), 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h3C01_0040;
      step();
      chk("if_ready",     32'(if_ready), 32'd1);
      chk("if_rdata",     if_rdata,      32'h3C01_0040);
      chk("if_req_drop",  32'(mem_req),  32'd0);
      chk("if_stall_rdy", 32'(pipe_stall), 32'd0);
      if_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      step();
      chk("if_ready_end", 32'(if_ready), 32'd0);
      chk("if_rdata_hold", if_rdata,     32'h3C01_0040);

      // Store with three wait cycles
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0000; dm_wdata = 32'hDEAD_BEEF;
      step();
      for (int i = 0; i < 4; i++) begin
         chk("st_mem_req",   32'(mem_req), 32'd1);
         chk("st_mem_we",    32'(mem_we),  32'd1);
         chk("st_mem_addr",  mem_addr,     32'h1001_0000);
         chk("st_mem_wdata", mem_wdata,    32'hDEAD_BEEF);
         chk("st_no_ready",  32'(dm_ready), 32'd0);
         if (i < 3) step();
      end
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      step();
      chk("st_dm_ready", 32'(dm_ready), 32'd1);
      chk("st_dm_rdata", dm_rdata,      32'd0);
      chk("st_mem_req0", 32'(mem_req),  32'd0);
      dm_req = 1'b0; mem_ack = 1'b0;
      step();
      chk("st_ready_end", 32'(dm_ready), 32'd0);

      // Load back the stored word
      dm_req = 1'b1; dm_we = 1'b0; dm_wdata = '0;
      step();
      chk("ld_mem_req", 32'(mem_req), 32'd1);
      chk("ld_mem_we",  32'(mem_we),  32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      step();
      chk("ld_dm_ready", 32'(dm_ready), 32'd1);
      chk("ld_dm_rdata", dm_rdata,      32'hDEAD_BEEF);
      dm_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      step();

      // A zero-wait store must not disturb the loaded value
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0008; dm_wdata = 32'h0BAD_F00D;
      step();
      chk("st2_mem_wdata", mem_wdata, 32'h0BAD_F00D);
      mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
      step();
      chk("st2_dm_ready", 32'(dm_ready), 32'd1);
      chk("st2_dm_rdata", dm_rdata,      32'hDEAD_BEEF);
      dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
      step();

      // Simultaneous requests: data first, fetch after one IDLE cycle
      if_req = 1'b1; if_addr = 32'h0040_0004;
      dm_req = 1'b1; dm_addr = 32'h1001_0004;
      step();
      chk("sim_d_addr",  mem_addr,         32'h1001_0004);
      chk("sim_d_stall", 32'(pipe_stall),  32'd1);
      mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
      step();
      chk("sim_d_ready", 32'(dm_ready),    32'd1);
      chk("sim_d_rdata", dm_rdata,         32'hAAAA_0001);
      chk("sim_stall1",  32'(pipe_stall),  32'd1);
      dm_req = 1'b0; mem_ack = 1'b0;
      step();
      chk("sim_idle_req", 32'(mem_req),    32'd0);
      chk("sim_stall2",   32'(pipe_stall), 32'd1);
      step();
      chk("sim_i_req",   32'(mem_req),     32'd1);
      chk("sim_i_addr",  mem_addr,         32'h0040_0004);
      mem_ack = 1'b1; mem_rdata = 32'h2008_0001;
      step();
      chk("sim_i_ready", 32'(if_ready),    32'd1);
      chk("sim_i_rdata", if_rdata,         32'h2008_0001);
      chk("sim_stall3",  32'(pipe_stall),  32'd0);
      if_req = 1'b0; mem_ack = 1'b0;
      step();

      // Starvation bound: D,D,D,D,I,D with both ports always requesting
      pc = 32'h0040_0008; da = 32'h1002_0000;
      if_req = 1'b1; if_addr = pc; dm_req = 1'b1; dm_addr = da;
      for (int g = 0; g < 6; g++) begin
         step();
         exp_addr = (g == 4) ? pc : da;
         chk("stv_grant_addr", mem_addr, exp_addr);
         chk("stv_mem_req",    32'(mem_req), 32'd1);
         mem_ack = 1'b1; mem_rdata = 32'hC000_0000 | 32'(g);
         step();
         chk("stv_if_ready", 32'(if_ready), (g == 4) ? 32'd1 : 32'd0);
         chk("stv_dm_ready", 32'(dm_ready), (g == 4) ? 32'd0 : 32'd1);
         mem_ack = 1'b0;
         if (g == 4) begin
            pc = pc + 32'd4; if_addr = pc;
         end else begin
            da = da + 32'd4; dm_addr = da;
         end
         step();
      end
      if_req = 1'b0; dm_req = 1'b0;
      step();

      // Reset in the middle of a data access
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0010;
      step();
      chk("mr_mem_req", 32'(mem_req), 32'd1);
      reset = 1'b1;
      step();
      chk("mr_mem_req0", 32'(mem_req),  32'd0);
      chk("mr_no_ready", 32'(dm_ready), 32'd0);
      chk("mr_rdata0",   dm_rdata,      32'd0);
      reset = 1'b0; dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
      step();
      chk("mr_late_ack_ready", 32'(dm_ready), 32'd0);
      chk("mr_late_ack_req",   32'(mem_req),  32'd0);
      step();
      chk("mr_late_ack_ready2", 32'(dm_ready), 32'd0);
      chk("mr_late_ack_irdy",   32'(if_ready), 32'd0);
      chk("mr_rdata_kept",      dm_rdata,      32'd0);
      mem_ack = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-port, variable-latency memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. It sits between the CPU core and a unified memory. Each grant is sequenced through a request/acknowledge handshake. The block drives a stall signal so the core freezes while either port waits. Data accesses win by default; a streak counter guarantees fetch progress.

## Interface
- `MAX_D_STREAK`, default 4: maximum consecutive data grants while a fetch is pending, before fetch is forced.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `if_req` input 1: fetch request; held with `if_addr` until `if_ready`.
- `if_addr` input 32: fetch word address (PC).
- `if_rdata` output 32: fetched instruction; valid when `if_ready`=1.
- `if_ready` output 1: one-cycle completion pulse for fetch.
- `dm_req` input 1: data request; held with `dm_we`/`dm_addr`/`dm_wdata` until `dm_ready`.
- `dm_we` input 1: 1 = store, 0 = load.
- `dm_addr` input 32: data address.
- `dm_wdata` input 32: store data.
- `dm_rdata` output 32: load data; valid when `dm_ready`=1 and the access was a load.
- `dm_ready` output 1: one-cycle completion pulse for data.
- `mem_req` output 1: memory request; held until `mem_ack`.
- `mem_we` output 1: memory write strobe, qualified by `mem_req`.
- `mem_addr` output 32: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_rdata` input 32: memory read data; valid in the `mem_ack` cycle.
- `mem_ack` input 1: memory completion; only meaningful while `mem_req`=1.
- `pipe_stall` output 1: freeze request to the core.

## Operation
- States: IDLE, IACC, DACC, IRESP, DRESP.
- **IDLE**: arbitration evaluates `if_req` and `dm_req` each cycle.
  - Only `dm_req` → DACC.
  - Only `if_req` → IACC.
  - Both, with `streak` < `MAX_D_STREAK` → DACC.
  - Both, with `streak` = `MAX_D_STREAK` → IACC.
  - Neither → stay in IDLE.
- **Entering IACC/DACC**: register `mem_addr`, `mem_we` and `mem_wdata` from the granted port and set `mem_req`=1.
  - For IACC, `mem_we`=0 and `mem_wdata`=0.
- **IACC/DACC**: hold all `mem_*` outputs stable while `mem_ack`=0. There is no timeout.
  - On `mem_ack`=1: clear `mem_req`.
  - For IACC, or DACC with `mem_we`=0, capture `mem_rdata` into `if_rdata`/`dm_rdata`.
  - Go to IRESP/DRESP.
- **IRESP/DRESP**: pulse `if_ready`/`dm_ready` for exactly one cycle, then go to IDLE.
  - Re-arbitration happens in IDLE on the following cycle.
- **Data stores**: `dm_rdata` is not updated and keeps its previous value.
- **Streak counter** (3+ bits, saturating at `MAX_D_STREAK`):
  - +1 on each DACC entry made while `if_req`=1.
  - Cleared on IACC entry.
  - Cleared on DACC entry made while `if_req`=0.
- **Stall**: `pipe_stall` = (`if_req` & ~`if_ready`) | (`dm_req` & ~`dm_ready`), combinational.
- **Undefined inputs**: a requester dropping `req` before `ready` is a protocol violation. An access already on the memory bus still completes, and its ready pulse is still issued.
- **Reset** (synchronous, mid-access included): state → IDLE; `mem_req`, `mem_we`, `if_ready`, `dm_ready` → 0; `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` → 0; `streak` → 0.
  - An in-flight memory access is abandoned, and no ready pulse follows.
  - `pipe_stall` follows its combinational equation.

## Timing
- Requests are sampled in IDLE at cycle T.
- `mem_req`=1 from T+1.
- For an ack in cycle T+k (k≥1), ready pulses at T+k+1 and the state returns to IDLE at T+k+2.
- Minimum request-to-ready latency is 2 cycles (zero-wait memory acking at T+1).
- Back-to-back grants are separated by one IDLE cycle, so throughput is at most one access per 3 cycles.
- `if_rdata`/`dm_rdata` are registered and hold their value after the ready pulse until the next capture.
- `mem_ack` arriving while `mem_req`=0 is ignored.

## Test plan
- **Reset**: assert `reset` 2 cycles with `if_req`=1 → all outputs 0 except `pipe_stall`=1; `mem_req`=0 throughout.
- **Lone fetch**: `if_req`=1, `if_addr`=0x00400000, memory acks next cycle with 0x3C010040 → `mem_req` high 1 cycle with `mem_addr`=0x00400000 and `mem_we`=0; `if_ready` pulses 2 cycles after request with `if_rdata`=0x3C010040.
- **Store then load**: `dm_we`=1, `dm_addr`=0x10010000, `dm_wdata`=0xDEADBEEF, ack after 3 wait cycles.
  - Required: `mem_we`=1, data held 4 cycles, `dm_ready` pulse, `dm_rdata` unchanged.
  - Then a load of 0x10010000 returning 0xDEADBEEF → `dm_rdata`=0xDEADBEEF.
- **Simultaneous requests**: `if_req` and `dm_req` asserted in the same cycle → data is granted first, fetch after one IDLE cycle; `pipe_stall`=1 until both ready pulses have occurred.
- **Starvation bound**: `dm_req` held continuously with new accesses, `if_req` held, `MAX_D_STREAK`=4 → grant order D,D,D,D,I,D…; the fetch completes within 5 grants.
- **Reset mid-access**: reset while in DACC with `mem_ack`=0 → next cycle IDLE and `mem_req`=0; no `dm_ready` pulse; a later ack is ignored.
